cla_arbiter: RTL

Two-requester, round-robin sharing controller for a single `cla_8bit` signed adder instance. Each requester submits an operand pair over a valid/ready handshake. The block serialises requests through the shared adder and registers the result. It optionally saturates on signed overflow or underflow, returns the response to the owning requester over a second valid/ready handshake, and counts range errors.

---
 rtl/cla_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/cla_arbiter.sv
// cla_arbiter: two-requester round-robin front end for one shared 8-bit
// carry-lookahead adder. It accepts one operand pair at a time, computes the
// sum, and can clamp the sum on signed overflow. It returns the response to
// the owning requester and counts responses that overflowed or underflowed.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   [1:0] operand handshake, bit i = requester i
//   req_a0/req_b0         requester 0 signed operands
//   req_a1/req_b1         requester 1 signed operands
//   rsp_valid/rsp_ready   [1:0] response handshake, bit i = requester i
//   rsp_sum               registered (optionally saturated) sum
//   rsp_ovf/rsp_uvf       positive / negative signed overflow of the raw sum
//   busy                  high outside IDLE
//   err_cnt/err_clr       saturating error-response count and its sync clear
// Parameter SATURATE: 1 clamps to 0x7F / 0x80 on ovf / uvf.

// 8-bit carry-lookahead adder with no carry-in or carry-out. Every carry is
// formed directly from the generate/propagate terms below it.
module cla_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] sum
);
    logic [7:0] g;
    logic [7:0] p;
    logic [7:0] c;

    always_comb begin
        logic term;
        // NOTE: every variable gets a value before any branch or loop, so
        // no path can leave it unassigned and infer a latch.
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        term = 1'b0;
        for (int i = 1; i < 8; i++) begin
            for (int j = 0; j < i; j++) begin
                term = g[j];
                for (int k = j + 1; k < i; k++) begin
                    term = term & p[k];
                end
                c[i] = c[i] | term;
            end
        end
        sum = p ^ c;
    end
endmodule

module cla_arbiter #(
    parameter bit SATURATE = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_valid,
    output logic [1:0] req_ready,
    input  logic [7:0] req_a0,
    input  logic [7:0] req_b0,
    input  logic [7:0] req_a1,
    input  logic [7:0] req_b1,
    output logic [1:0] rsp_valid,
    input  logic [1:0] rsp_ready,
    output logic [7:0] rsp_sum,
    output logic       rsp_ovf,
    output logic       rsp_uvf,
    output logic       busy,
    output logic [7:0] err_cnt,
    input  logic       err_clr
);
    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    state_t     state;
    state_t     state_nxt;
    logic       last_grant;
    logic       owner;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic       gnt_sel;
    logic       accept;
    logic       rsp_done;
    logic [7:0] raw_sum;
    logic       raw_ovf;
    logic       raw_uvf;
    logic [7:0] res_sum;

    // A tie goes to the requester that was not served last; otherwise the
    // single valid requester (bit 1 set means requester 1).
    assign gnt_sel = (req_valid == 2'b11) ? ~last_grant : req_valid[1];

    // Gated by rst_n so req_ready reads 0 while reset is held, whatever
    // req_valid does.
    assign req_ready = (rst_n && state == IDLE && req_valid != 2'b00)
                     ? (gnt_sel ? 2'b10 : 2'b01) : 2'b00;
    assign accept    = |(req_valid & req_ready);
    assign rsp_valid = (state == RESP) ? (owner ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_done  = (state == RESP) && rsp_ready[owner];
    assign busy      = (state != IDLE);

    cla_8bit u_cla (
        .a   (op_a),
        .b   (op_b),
        .sum (raw_sum)
    );

    assign raw_ovf = ~op_a[7] & ~op_b[7] &  raw_sum[7];
    assign raw_uvf =  op_a[7] &  op_b[7] & ~raw_sum[7];

    always_comb begin
        res_sum = raw_sum;
        if (SATURATE && raw_ovf) res_sum = 8'h7F;
        if (SATURATE && raw_uvf) res_sum = 8'h80;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)   state_nxt = CALC;
            CALC:                  state_nxt = RESP;
            RESP:    if (rsp_done) state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a       <= '0;
            op_b       <= '0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            rsp_sum    <= '0;
            rsp_ovf    <= 1'b0;
            rsp_uvf    <= 1'b0;
        end else begin
            if (accept) begin
                op_a  <= gnt_sel ? req_a1 : req_a0;
                op_b  <= gnt_sel ? req_b1 : req_b0;
                owner <= gnt_sel;
            end
            if (state == CALC) begin
                rsp_sum <= res_sum;
                rsp_ovf <= raw_ovf;
                rsp_uvf <= raw_uvf;
            end
            if (rsp_done) last_grant <= owner;
        end
    end

    // Clear wins over a simultaneous increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (err_clr) begin
            err_cnt <= '0;
        end else if (rsp_done && (rsp_ovf || rsp_uvf) && err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
endmodule
